// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: sequences FETCH/DECODE/EXECUTE/MEM/WB
// and drives the datapath strobes and selects combinationally from state, opcode, funct and zero.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  PC_choice,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [1:0]  alu_op,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_UNDEF
  } instr_t;

  state_t st, st_nxt;
  instr_t ins;

  assign state = st;

  always_comb begin
    ins = I_UNDEF;
    case (opcode)
      6'h00: case (funct)
        6'h21:   ins = I_ADDU;
        6'h23:   ins = I_SUBU;
        6'h08:   ins = I_JR;
        default: ins = I_UNDEF;
      endcase
      6'h0d:   ins = I_ORI;
      6'h0f:   ins = I_LUI;
      6'h23:   ins = I_LW;
      6'h2b:   ins = I_SW;
      6'h04:   ins = I_BEQ;
      6'h02:   ins = I_J;
      6'h03:   ins = I_JAL;
      default: ins = I_UNDEF;
    endcase
  end

  always_comb begin
    pc_we     = 1'b0;
    PC_choice = 2'b00;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    alu_src   = 1'b0;
    ext_op    = 2'b00;
    alu_op    = 2'b00;
    mem_we    = 1'b0;
    st_nxt    = S_FETCH;
    case (st)
      S_FETCH: begin
        ir_we  = 1'b1;
        st_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (ins)
          I_J: begin
            pc_we     = 1'b1;
            PC_choice = 2'b10;
          end
          I_JAL: begin
            pc_we     = 1'b1;
            PC_choice = 2'b10;
            reg_we    = 1'b1;
            reg_dst   = 2'b10;
            wd_sel    = 2'b10;
          end
          I_JR: begin
            pc_we     = 1'b1;
            PC_choice = 2'b11;
          end
          I_UNDEF: pc_we = 1'b1;  // retires as a nop, PC+4
          default: st_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (ins)
          I_ADDU: st_nxt = S_WB;
          I_SUBU: begin
            alu_op = 2'b01;
            st_nxt = S_WB;
          end
          I_ORI: begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
            st_nxt  = S_WB;
          end
          I_LUI: begin
            alu_src = 1'b1;
            ext_op  = 2'b10;
            alu_op  = 2'b10;
            st_nxt  = S_WB;
          end
          I_LW, I_SW: begin
            alu_src = 1'b1;
            ext_op  = 2'b01;
            st_nxt  = S_MEM;
          end
          I_BEQ: begin
            alu_op    = 2'b01;
            pc_we     = 1'b1;
            PC_choice = zero ? 2'b01 : 2'b00;
          end
          default: st_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        // address path stays as in EXECUTE so the memory sees a stable address while stalled
        alu_src = 1'b1;
        ext_op  = 2'b01;
        mem_we  = (ins == I_SW);
        if (!mem_ready)
          st_nxt = S_MEM;
        else if (ins == I_SW)
          pc_we = 1'b1;
        else
          st_nxt = S_WB;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (ins == I_ADDU || ins == I_SUBU) reg_dst = 2'b01;
        if (ins == I_LW) wd_sel = 2'b01;
      end
      default: st_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_FETCH;
      instr_count <= 32'd0;
    end else begin
      st <= st_nxt;
      if (pc_we) instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle schedules checked cycle by cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_we, ir_we, reg_we, alu_src, mem_we;
  logic [1:0]  PC_choice, reg_dst, wd_sel, ext_op, alu_op;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int n_vec = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .PC_choice(PC_choice), .ir_we(ir_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .ext_op(ext_op), .alu_op(alu_op), .mem_we(mem_we), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pcc;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       mem_we;
  } rec_t;

  rec_t exp_q[$];

  function automatic rec_t observed();
    rec_t r;
    r.st = state; r.pc_we = pc_we; r.pcc = PC_choice; r.ir_we = ir_we;
    r.reg_we = reg_we; r.reg_dst = reg_dst; r.wd_sel = wd_sel; r.alu_src = alu_src;
    r.ext_op = ext_op; r.alu_op = alu_op; r.mem_we = mem_we;
    return r;
  endfunction

  // Instruction names as the ISA defines them
  function automatic string kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h21) ? "addu" : (fn == 6'h23) ? "subu" : (fn == 6'h08) ? "jr" : "undef";
      6'h0d:   return "ori";
      6'h0f:   return "lui";
      6'h23:   return "lw";
      6'h2b:   return "sw";
      6'h04:   return "beq";
      6'h02:   return "j";
      6'h03:   return "jal";
      default: return "undef";
    endcase
  endfunction

  // Expected per-cycle schedule of one instruction from its textual semantics
  task automatic build(input string k, input logic z, input int stalls);
    rec_t r;
    exp_q.delete();
    r = '0; r.ir_we = 1'b1; exp_q.push_back(r);
    r = '0; r.st = 3'd1;
    if (k == "j" || k == "jal" || k == "jr" || k == "undef") begin
      r.pc_we = 1'b1;
      r.pcc = (k == "jr") ? 2'b11 : (k == "undef") ? 2'b00 : 2'b10;
      if (k == "jal") begin r.reg_we = 1'b1; r.reg_dst = 2'b10; r.wd_sel = 2'b10; end
      exp_q.push_back(r);
      return;
    end
    exp_q.push_back(r);
    r = '0; r.st = 3'd2;
    if (k == "subu" || k == "beq") r.alu_op = 2'b01;
    if (k == "ori" || k == "lui") begin r.alu_src = 1'b1; r.alu_op = 2'b10; end
    if (k == "lui") r.ext_op = 2'b10;
    if (k == "lw" || k == "sw") begin r.alu_src = 1'b1; r.ext_op = 2'b01; end
    if (k == "beq") begin r.pc_we = 1'b1; r.pcc = z ? 2'b01 : 2'b00; end
    exp_q.push_back(r);
    if (k == "beq") return;
    if (k == "lw" || k == "sw") begin
      r = '0; r.st = 3'd3; r.alu_src = 1'b1; r.ext_op = 2'b01; r.mem_we = (k == "sw");
      for (int s = 0; s < stalls; s++) exp_q.push_back(r);
      r.pc_we = (k == "sw");
      exp_q.push_back(r);
      if (k == "sw") return;
    end
    r = '0; r.st = 3'd4; r.reg_we = 1'b1; r.pc_we = 1'b1;
    if (k == "addu" || k == "subu") r.reg_dst = 2'b01;
    if (k == "lw") r.wd_sel = 2'b01;
    exp_q.push_back(r);
  endtask

  // Entered 1 time unit after a rising edge with the DUT in FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int stalls, input string tag);
    string k;
    int mcnt;
    logic [31:0] cnt0;
    rec_t got;
    k = kind(op, fn);
    build(k, z, stalls);
    cnt0 = instr_count;
    mcnt = 0;
    opcode = op; funct = fn;
    foreach (exp_q[i]) begin
      zero = (k == "beq" && exp_q[i].st == 3'd2) ? z : 1'($urandom);
      if (exp_q[i].st == 3'd3) begin
        mem_ready = (mcnt < stalls) ? 1'b0 : 1'b1;
        mcnt++;
      end else begin
        mem_ready = 1'($urandom);
      end
      #1;
      got = observed();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s(%s) cycle %0d: outputs got %h expected %h", tag, k, i, got, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (state !== 3'd0 || instr_count !== cnt0 + 32'd1) begin
      n_err++;
      $display("FAIL %s(%s) retire: state/count got %0d/%0d expected 0/%0d", tag, k, state, instr_count, cnt0 + 32'd1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    #2;
    n_vec++;
    if (state !== 3'd0 || instr_count !== 32'd0 || ir_we !== 1'b1 || pc_we !== 1'b0 ||
        reg_we !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset: state %0d count %0d ir_we %b pc_we %b reg_we %b mem_we %b, need 0 0 1 0 0 0",
               state, instr_count, ir_we, pc_we, reg_we, mem_we);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_addu();      run_instr(6'h00, 6'h21, 1'b0, 0, "addu"); endtask
  task automatic test_lw_stall();  run_instr(6'h23, 6'h15, 1'b1, 3, "lw_stall"); endtask
  task automatic test_beq();
    run_instr(6'h04, 6'h00, 1'b1, 0, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, 0, "beq_not_taken");
  endtask
  task automatic test_jal_jr();
    run_instr(6'h03, 6'h11, 1'b0, 0, "jal");
    run_instr(6'h00, 6'h08, 1'b0, 0, "jr");
  endtask
  task automatic test_undef_sw();
    run_instr(6'h3f, 6'h21, 1'b0, 0, "undef");
    run_instr(6'h2b, 6'h00, 1'b0, 0, "sw");
    run_instr(6'h00, 6'h22, 1'b0, 0, "undef_funct");
  endtask

  task automatic test_random();
    logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    logic [5:0] fns[3]  = '{6'h21, 6'h23, 6'h08};
    logic [5:0] op, fn;
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 9)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 2)] : 6'($urandom);
      if ($urandom_range(0, 7) == 0) begin op = 6'($urandom); fn = 6'($urandom); end
      run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_reset_mid_sw();
    int guard;
    reset = 1'b1; #1; reset = 1'b0;
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (state !== 3'd3 || mem_we !== 1'b1 || pc_we !== 1'b0) begin
      n_err++;
      $display("FAIL sw_mem_stall: state %0d mem_we %b pc_we %b, need 3 1 0", state, mem_we, pc_we);
    end
    reset = 1'b1; #1;
    n_vec++;
    if (state !== 3'd0 || mem_we !== 1'b0 || instr_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_sw: state %0d mem_we %b count %0d, need 0 0 0", state, mem_we, instr_count);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (state !== 3'd0 || instr_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_held: state %0d count %0d, need 0 0", state, instr_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL first_edge_after_reset: state %0d, need 1", state);
    end
    guard = 0;
    while (state !== 3'd0 && guard < 20) begin @(posedge clk); #1; guard++; end
    n_vec++;
    if (state !== 3'd0 || instr_count !== 32'd1) begin
      n_err++;
      $display("FAIL sw_after_reset: state %0d count %0d, need 0 1", state, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_jal_jr();
    test_undef_sw();
    test_random();
    test_reset_mid_sw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
